// File: rtl/prbs_pkg.sv
// PRBS9 constants shared by the transmit generator and the receive-side checker.
// Polynomial x^9 + x^5 + 1; taps are state bit indices of a left-shifting 9-bit LFSR.
package prbs_pkg;

    localparam int          PRBS9_TAP_HI  = 8;
    localparam int          PRBS9_TAP_LO  = 4;
    localparam int          PRBS9_LEN     = 511;
    localparam logic [8:0]  PRBS9_SEED    = 9'h1AA;

    // An all-zero seed would lock the LFSR, so it is swapped for all-ones.
    function automatic logic [8:0] prbs9_legal_seed(input logic [8:0] seed);
        return (seed == 9'h000) ? 9'h1FF : seed;
    endfunction

endpackage

// File: rtl/prbs9_lfsr.sv
// PRBS9 LFSR: loads the legal seed on reset/load, advances one step per i_adv.
// Latency: state updates the cycle after i_adv; no backpressure, the caller paces it.
module prbs9_lfsr
    import prbs_pkg::*;
#(
    parameter logic [8:0] SEED = PRBS9_SEED
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic       i_adv,
    output logic [8:0] o_state,
    output logic       o_bit
);

    localparam logic [8:0] LOAD_VAL = prbs9_legal_seed(SEED);

    logic [8:0] state_q;
    logic [8:0] state_d;

    always_comb begin
        state_d = {state_q[7:0], state_q[PRBS9_TAP_HI] ^ state_q[PRBS9_TAP_LO]};
    end

    always_ff @(posedge clk) begin
        if (i_reset || i_load) begin
            state_q <= LOAD_VAL;
        end else if (i_adv) begin
            state_q <= state_d;
        end
    end

    assign o_state = state_q;
    assign o_bit   = state_q[8];

endmodule

// File: rtl/prbs_tx_gen.sv
// Transmit PRBS9 source with period flag, periodic error injection and saturating counters.
// Latency: bit k appears one clk after strobe k and holds; no backpressure, paced by i_ctrl.
module prbs_tx_gen
    import prbs_pkg::*;
#(
    parameter logic [8:0] SEED         = PRBS9_SEED,
    parameter int         PRBS_LEN     = PRBS9_LEN,
    parameter int         CNT_BITS     = 32,
    parameter int         ERR_CNT_BITS = 16
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    i_en_tx,
    input  logic                    i_ctrl,
    input  logic                    i_err_inj_en,
    input  logic [ERR_CNT_BITS-1:0] i_err_period,
    output logic                    o_bit,
    output logic                    o_seq_start,
    output logic                    o_err_injected,
    output logic [CNT_BITS-1:0]     o_tx_bits,
    output logic [ERR_CNT_BITS-1:0] o_err_count
);

    localparam int PH_W = $clog2(PRBS_LEN);

    logic                    clr;
    logic                    lfsr_bit;
    logic [8:0]              lfsr_state;
    logic                    lfsr_stuck;
    logic                    inj_arm;
    logic                    inj;

    logic [PH_W-1:0]         phase_q,    phase_d;
    logic [ERR_CNT_BITS-1:0] err_cnt_q,  err_cnt_d;
    logic                    bit_q,      bit_d;
    logic                    seq_q,      seq_d;
    logic                    injd_q,     injd_d;
    logic [CNT_BITS-1:0]     tx_bits_q,  tx_bits_d;
    logic [ERR_CNT_BITS-1:0] err_tot_q,  err_tot_d;

    assign clr = i_reset | ~i_en_tx;

    // Zero state cannot occur from a legal seed; reloading guards against upsets.
    assign lfsr_stuck = (lfsr_state == 9'h000);

    prbs9_lfsr #(
        .SEED    (SEED)
    ) u_lfsr (
        .clk     (clk),
        .i_reset (i_reset),
        .i_load  (~i_en_tx | lfsr_stuck),
        .i_adv   (i_ctrl),
        .o_state (lfsr_state),
        .o_bit   (lfsr_bit)
    );

    // Exact-match compare: shrinking the period below err_cnt defers injection until wrap.
    assign inj_arm = i_err_inj_en && (i_err_period != '0);
    assign inj     = inj_arm && (err_cnt_q == (i_err_period - ERR_CNT_BITS'(1)));

    always_comb begin
        phase_d   = phase_q;
        err_cnt_d = err_cnt_q;
        bit_d     = bit_q;
        seq_d     = seq_q;
        injd_d    = injd_q;
        tx_bits_d = tx_bits_q;
        err_tot_d = err_tot_q;
        if (i_ctrl) begin
            bit_d   = lfsr_bit ^ inj;
            injd_d  = inj;
            seq_d   = (phase_q == '0);
            phase_d = (phase_q == PH_W'(PRBS_LEN - 1)) ? '0 : phase_q + PH_W'(1);
            if (tx_bits_q != '1) begin
                tx_bits_d = tx_bits_q + CNT_BITS'(1);
            end
            if (inj) begin
                err_cnt_d = '0;
                if (err_tot_q != '1) begin
                    err_tot_d = err_tot_q + ERR_CNT_BITS'(1);
                end
            end else if (inj_arm) begin
                err_cnt_d = err_cnt_q + ERR_CNT_BITS'(1);
            end else begin
                err_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            phase_q   <= '0;
            err_cnt_q <= '0;
            bit_q     <= 1'b0;
            seq_q     <= 1'b0;
            injd_q    <= 1'b0;
            tx_bits_q <= '0;
            err_tot_q <= '0;
        end else begin
            phase_q   <= phase_d;
            err_cnt_q <= err_cnt_d;
            bit_q     <= bit_d;
            seq_q     <= seq_d;
            injd_q    <= injd_d;
            tx_bits_q <= tx_bits_d;
            err_tot_q <= err_tot_d;
        end
    end

    assign o_bit          = bit_q;
    assign o_seq_start    = seq_q;
    assign o_err_injected = injd_q;
    assign o_tx_bits      = tx_bits_q;
    assign o_err_count    = err_tot_q;

endmodule

// File: tb/tb_prbs_tx_gen.sv
// Bench for prbs_tx_gen: directed phases plus random strobing, checked every cycle
// against a recurrence-based PRBS9 model (o[n] = o[n-9] ^ o[n-5]) and counter arithmetic.
module tb_prbs_tx_gen;

    localparam logic [8:0] SEED_V = 9'h1AA;
    localparam longint     TX_MAX = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_en_tx = 1'b0;
    logic        i_ctrl = 1'b0;
    logic        i_err_inj_en = 1'b0;
    logic [15:0] i_err_period = '0;
    logic [3:0]  p_small = '0;

    logic        o_bit, o_seq_start, o_err_injected;
    logic [31:0] o_tx_bits;
    logic [15:0] o_err_count;
    logic        s_bit_o, s_seq_o, s_inj_o;
    logic [3:0]  s_tx_o, s_errc_o;

    always #5 clk = ~clk;

    prbs_tx_gen #(.SEED(SEED_V), .CNT_BITS(32), .ERR_CNT_BITS(16)) dut (
        .clk(clk), .i_reset(i_reset), .i_en_tx(i_en_tx), .i_ctrl(i_ctrl),
        .i_err_inj_en(i_err_inj_en), .i_err_period(i_err_period),
        .o_bit(o_bit), .o_seq_start(o_seq_start), .o_err_injected(o_err_injected),
        .o_tx_bits(o_tx_bits), .o_err_count(o_err_count)
    );

    prbs_tx_gen #(.SEED(SEED_V), .CNT_BITS(4), .ERR_CNT_BITS(4)) dut_small (
        .clk(clk), .i_reset(i_reset), .i_en_tx(i_en_tx), .i_ctrl(i_ctrl),
        .i_err_inj_en(i_err_inj_en), .i_err_period(p_small),
        .o_bit(s_bit_o), .o_seq_start(s_seq_o), .o_err_injected(s_inj_o),
        .o_tx_bits(s_tx_o), .o_err_count(s_errc_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Golden one-period PRBS9 output sequence.
    bit gold [0:510];

    // Reference model state.
    int     m_idx = 0, m_ecnt = 0, s_ecnt = 0;
    bit     m_bit = 0, m_seq = 0, m_inj = 0;
    longint m_tx = 0;
    int     m_errc = 0;
    bit     s_bit = 0, s_seq = 0, s_inj = 0;
    int     s_tx = 0, s_errc = 0;
    int     pos, p, ps;
    bit     arm, inj, sarm, sinj;
    bit     chk_on = 0;

    always @(posedge clk) begin
        if (i_reset || !i_en_tx) begin
            m_idx = 0; m_ecnt = 0; s_ecnt = 0;
            m_bit = 0; m_seq = 0; m_inj = 0; m_tx = 0; m_errc = 0;
            s_bit = 0; s_seq = 0; s_inj = 0; s_tx = 0; s_errc = 0;
        end else if (i_ctrl) begin
            pos  = m_idx % 511;
            p    = int'(i_err_period);
            ps   = int'(p_small);
            arm  = i_err_inj_en && (p != 0);
            sarm = i_err_inj_en && (ps != 0);
            inj  = arm  ? ((m_ecnt % p)  == p - 1)  : 1'b0;
            sinj = sarm ? ((s_ecnt % ps) == ps - 1) : 1'b0;
            m_ecnt = arm  ? m_ecnt + 1 : 0;
            s_ecnt = sarm ? s_ecnt + 1 : 0;
            m_bit = gold[pos] ^ inj;  m_seq = (pos == 0); m_inj = inj;
            s_bit = gold[pos] ^ sinj; s_seq = (pos == 0); s_inj = sinj;
            if (m_tx < TX_MAX) m_tx++;
            if (s_tx < 15) s_tx++;
            if (inj && m_errc < 65535) m_errc++;
            if (sinj && s_errc < 15) s_errc++;
            m_idx++;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("bit",       o_bit,          m_bit);
            chk("seq_start", o_seq_start,    m_seq);
            chk("err_inj",   o_err_injected, m_inj);
            chk("tx_bits",   o_tx_bits,      m_tx);
            chk("err_count", o_err_count,    m_errc);
            chk("s_bit",     s_bit_o,        s_bit);
            chk("s_seq",     s_seq_o,        s_seq);
            chk("s_inj",     s_inj_o,        s_inj);
            chk("s_tx",      s_tx_o,         s_tx);
            chk("s_errc",    s_errc_o,       s_errc);
        end
    end

    // Reconfigure while disabled, then re-enable with the strobe idle.
    task automatic restart(input bit en_inj, input logic [15:0] per, input logic [3:0] per_s);
        i_ctrl  = 1'b0;
        i_en_tx = 1'b0;
        i_err_inj_en = en_inj;
        i_err_period = per;
        p_small      = per_s;
        @(negedge clk);
        i_en_tx = 1'b1;
    endtask

    task automatic strobes(input int n);
        i_ctrl = 1'b1;
        repeat (n) @(negedge clk);
        i_ctrl = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bit"}, o_bit, 0);
        chk({tag, "_seq"}, o_seq_start, 0);
        chk({tag, "_inj"}, o_err_injected, 0);
        chk({tag, "_tx"},  o_tx_bits, 0);
        chk({tag, "_ec"},  o_err_count, 0);
    endtask

    logic [15:0] per_tab [0:4];

    initial begin
        for (int i = 0; i < 9; i++) gold[i] = SEED_V[8-i];
        for (int i = 9; i < 511; i++) gold[i] = gold[i-9] ^ gold[i-5];
        per_tab[0] = 16'd0; per_tab[1] = 16'd1; per_tab[2] = 16'd3;
        per_tab[3] = 16'd7; per_tab[4] = 16'd100;

        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        chk_all_zero("reset");

        // Continuous strobing across two full periods.
        i_reset = 1'b0;
        i_en_tx = 1'b1;
        strobes(1100);

        // One strobe in four.
        restart(1'b0, 16'd0, 4'd0);
        for (int i = 0; i < 400; i++) begin
            i_ctrl = (i % 4 == 0);
            @(negedge clk);
        end
        i_ctrl = 1'b0;
        chk("gated_tx", o_tx_bits, 100);

        // Injection every 100 bits, then period 0.
        restart(1'b1, 16'd100, 4'd0);
        strobes(500);
        chk("inj_count", o_err_count, 5);
        restart(1'b1, 16'd0, 4'd0);
        strobes(300);
        chk("inj_off_count", o_err_count, 0);

        // Disable mid-run, then the same with reset.
        for (int k = 0; k < 2; k++) begin
            restart(1'b0, 16'd0, 4'd0);
            strobes(250);
            i_ctrl = 1'b1;
            if (k == 0) i_en_tx = 1'b0; else i_reset = 1'b1;
            repeat (3) @(negedge clk);
            chk_all_zero(k == 0 ? "dis" : "rst");
            i_en_tx = 1'b1;
            i_reset = 1'b0;
            @(negedge clk);
            chk("restart_seq", o_seq_start, 1);
            chk("restart_tx",  o_tx_bits, 1);
            strobes(20);
        end

        // Saturation of the narrow instance with injection on every bit.
        restart(1'b1, 16'd1, 4'd1);
        strobes(40);
        chk("sat_tx",   s_tx_o, 15);
        chk("sat_errc", s_errc_o, 15);
        chk("sat_main_errc", o_err_count, 40);

        // Reset in the same cycle as a strobe.
        restart(1'b0, 16'd0, 4'd0);
        strobes(10);
        i_reset = 1'b1;
        i_ctrl  = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_strobe");
        chk("rst_strobe_lfsr", dut.lfsr_state, SEED_V);
        i_reset = 1'b0;
        strobes(10);

        // Random strobing with occasional restarts and new injection settings.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                restart(1'($urandom_range(0, 1)), per_tab[$urandom_range(0, 4)],
                        4'($urandom_range(0, 15)));
            end else if ($urandom_range(0, 299) == 0) begin
                i_reset = 1'b1;
                i_ctrl  = 1'($urandom_range(0, 1));
                @(negedge clk);
                i_reset = 1'b0;
            end
            i_ctrl = 1'($urandom_range(0, 1));
            @(negedge clk);
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
